// File: rtl/sdio_data_tx_sequencer.sv
// SDIO DAT-line block transmitter: start bit, payload, per-lane CRC16, end bit.
// Pulls payload bytes over valid/ready; supports 1-bit and 4-bit bus modes.
module sdio_data_tx_sequencer #(
  parameter logic [15:0] POLYNOMIAL = 16'h1021,
  parameter logic [15:0] SEED       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        wide,
  input  logic [10:0] block_size,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [3:0]  sd_dat_out,
  output logic [3:0]  sd_dat_oe,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_DATA, S_CRC, S_END
  } state_t;

  state_t      state, state_next;
  logic        wide_q;
  logic [11:0] remaining;
  logic [2:0]  bit_cnt;
  logic [3:0]  crc_cnt;
  logic [7:0]  shreg;
  logic [15:0] crc [4];
  logic        underrun_q;
  logic        done_q;
  logic        last_bit;
  logic [3:0]  lane_bits;
  logic [3:0]  crc_bits;
  logic [3:0]  lane_oe;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    last_bit   = wide_q ? bit_cnt[0] : (bit_cnt == 3'd7);
    lane_bits  = wide_q ? shreg[7:4] : {3'b111, shreg[7]};
    crc_bits   = wide_q ? {crc[3][15], crc[2][15], crc[1][15], crc[0][15]}
                        : {3'b111, crc[0][15]};
    lane_oe    = wide_q ? 4'b1111 : 4'b0001;
    state_next = state;
    data_ready = 1'b0;
    sd_dat_out = '1;
    sd_dat_oe  = '0;
    unique case (state)
      S_IDLE: if (start && !abort) state_next = S_WAIT;
      S_WAIT: begin
        data_ready = 1'b1;
        if (data_valid) state_next = S_START;
      end
      S_START: begin
        sd_dat_out = ~lane_oe;
        sd_dat_oe  = lane_oe;
        state_next = S_DATA;
      end
      S_DATA: begin
        sd_dat_out = lane_bits;
        sd_dat_oe  = lane_oe;
        // remaining counts bytes still to fetch after the one being shifted
        if (last_bit) begin
          if (remaining != 12'd0) data_ready = 1'b1;
          else                    state_next = S_CRC;
        end
      end
      S_CRC: begin
        sd_dat_out = crc_bits;
        sd_dat_oe  = lane_oe;
        if (crc_cnt == 4'd15) state_next = S_END;
      end
      S_END: begin
        sd_dat_oe  = lane_oe;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wide_q     <= 1'b0;
      remaining  <= '0;
      bit_cnt    <= '0;
      crc_cnt    <= '0;
      shreg      <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) crc[i] <= '0;
    end else begin
      done_q <= (state == S_END) && !abort;
      if (!abort) begin
        unique case (state)
          S_IDLE: if (start) begin
            wide_q     <= wide;
            remaining  <= (block_size == 11'd0) ? 12'd2048 : {1'b0, block_size};
            underrun_q <= 1'b0;
          end
          S_WAIT: if (data_valid) begin
            shreg     <= data_in;
            remaining <= remaining - 12'd1;
            bit_cnt   <= '0;
          end
          S_START: begin
            crc_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) crc[i] <= SEED;
          end
          S_DATA: begin
            for (int unsigned i = 0; i < 4; i++)
              crc[i] <= {crc[i][14:0], 1'b0} ^
                        ((lane_bits[i] ^ crc[i][15]) ? POLYNOMIAL : 16'h0000);
            if (last_bit) begin
              bit_cnt <= '0;
              if (remaining != 12'd0) begin
                remaining <= remaining - 12'd1;
                if (data_valid) begin
                  shreg <= data_in;
                end else begin
                  shreg      <= '0;
                  underrun_q <= 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= wide_q ? {shreg[3:0], 4'b0000} : {shreg[6:0], 1'b0};
            end
          end
          S_CRC: begin
            crc_cnt <= crc_cnt + 4'd1;
            for (int unsigned i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule
